// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN pipeline stages.
// Widths, FSM state encoding and Q3.12 saturation limits.
package cnn_pkg;

    localparam int DW   = 13;
    localparam int WW   = 13;
    localparam int OW   = 16;
    localparam int FRAC = 12;
    localparam int ACCW = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        SCALE,
        HOLD
    } state_t;

    localparam logic [OW-1:0] SAT_MAX = 16'h7FFF;
    localparam logic [OW-1:0] SAT_MIN = 16'h8000;

endpackage

// File: rtl/sat_shift.sv
// Shift an accumulator left by FRAC and clamp it to the signed OW range.
// Purely combinational; shared by the dense stages.
module sat_shift
    import cnn_pkg::*;
(
    input  logic [ACCW-1:0] acc,
    output logic [OW-1:0]   result
);

    localparam int WIDE = ACCW + FRAC;

    logic [WIDE-1:0] wide;
    logic            fits;

    assign wide = {acc, {FRAC{1'b0}}};

    // Fits when every bit above the output sign bit copies it.
    assign fits = (&wide[WIDE-1:OW-1]) | ~(|wide[WIDE-1:OW-1]);

    always_comb begin
        result = wide[OW-1:0];
        if (!fits) begin
            result = wide[WIDE-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/dense_neuron.sv
// Single fully-connected neuron: bias plus weighted sum of a serial
// feature stream, scaled to saturated Q3.12 behind a valid/ready port.
module dense_neuron
    import cnn_pkg::*;
#(
    parameter int                 N_IN   = 4,
    parameter logic [DW-1:0]      BIAS   = '0,
    parameter logic [N_IN*WW-1:0] W_INIT = {13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h0001}
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          w_we,
    input  logic [5:0]    w_addr,
    input  logic [WW-1:0] w_data,
    input  logic          start,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          done
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int NW    = 1 << IDX_W;
    localparam logic [NW*WW-1:0] W_PAD = (NW*WW)'(W_INIT);
    localparam logic [ACCW-1:0]  BIAS_EXT = {{(ACCW-DW){BIAS[DW-1]}}, BIAS};

    state_t state;
    state_t next;

    logic [IDX_W-1:0]    idx;
    logic [ACCW-1:0]     acc;
    logic [WW-1:0]       w [NW];
    logic [DW+WW-1:0]    prod;
    logic [ACCW-1:0]     prod_ext;
    logic [OW-1:0]       scaled;
    logic                beat;
    logic                last;
    logic                w_ok;

    assign beat     = in_valid && in_ready;
    assign last     = idx == IDX_W'(N_IN - 1);
    assign prod     = $signed(in_data) * $signed(w[idx]);
    assign prod_ext = {{(ACCW-DW-WW){prod[DW+WW-1]}}, prod};
    assign w_ok     = w_we && ({1'b0, w_addr} < 7'(N_IN));

    sat_shift u_sat (
        .acc    (acc),
        .result (scaled)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:  if (start) next = ACC;
            ACC:   if (beat && last) next = SCALE;
            SCALE: next = HOLD;
            HOLD:  if (out_ready) next = IDLE;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        unique case (state)
            IDLE:  busy = 1'b0;
            ACC:   in_ready = 1'b1;
            SCALE: ;
            HOLD:  out_valid = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= BIAS_EXT;
            idx      <= '0;
            out_data <= '0;
            done     <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                w[i] <= W_PAD[i*WW +: WW];
            end
        end else begin
            done <= (state == HOLD) && out_ready;
            unique case (state)
                IDLE: begin
                    acc <= BIAS_EXT;
                    idx <= '0;
                    if (w_ok) begin
                        w[w_addr[IDX_W-1:0]] <= w_data;
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc <= acc + prod_ext;
                        idx <= idx + 1'b1;
                    end
                end
                SCALE: out_data <= scaled;
                HOLD: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_neuron.sv
// Self-checking bench for dense_neuron: directed vector table,
// reset/chaining sequences and randomized runs against a sum model.
module tb_dense_neuron;

    logic        clk = 1'b0;
    logic        rst;
    logic        w_we;
    logic [5:0]  w_addr;
    logic [12:0] w_data;
    logic        start;
    logic        in_valid;
    logic [12:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    bit chained = 1'b0;
    int model_w[4];

    dense_neuron dut (
        .clk       (clk),
        .rst       (rst),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][12:0] f;
        bit               wr;
        logic [5:0]       wa;
        int               wd;
        logic [15:0]      exp;
        bit               toggle;
        int               stall;
        bit               disturb;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model;
        model_w[0] = 1;
        model_w[1] = -1;
        model_w[2] = -1;
        model_w[3] = -1;
    endtask

    task automatic write_w(input logic [5:0] a, input int d);
        w_we   = 1'b1;
        w_addr = a;
        w_data = 13'(d);
        step;
        w_we   = 1'b0;
        if (a < 6'd4) model_w[a[1:0]] = d;
    endtask

    function automatic logic [15:0] expect_q(input int f[4]);
        longint s;
        s = 0;
        for (int i = 0; i < 4; i++) s += longint'(f[i]) * model_w[i];
        s = s * 4096;
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return s[15:0];
    endfunction

    task automatic run(input int f[4], input bit toggle, input int stall,
                       input bit disturb, input bit chain,
                       output logic [15:0] res);
        if (!chained) begin
            start = 1'b1;
            step;
            start = 1'b0;
        end
        chained = 1'b0;
        check("in_ready_after_start", in_ready, 1);
        check("busy_in_acc", busy, 1);
        for (int i = 0; i < 4; i++) begin
            if (toggle) begin
                in_valid = 1'b0;
                step;
            end
            in_valid = 1'b1;
            in_data  = 13'(f[i]);
            if (disturb && i == 1) begin
                start  = 1'b1;
                w_we   = 1'b1;
                w_addr = 6'd0;
                w_data = 13'd5;
            end
            step;
            start = 1'b0;
            w_we  = 1'b0;
        end
        in_data = 13'd7;
        check("in_ready_drop", in_ready, 0);
        check("out_valid_early", out_valid, 0);
        step;
        in_valid = 1'b0;
        check("out_valid_latency", out_valid, 1);
        res = out_data;
        for (int s = 0; s < stall; s++) begin
            if (disturb) begin
                in_valid = 1'b1;
                in_data  = 13'd9;
            end
            step;
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, res);
            check("hold_no_done", done, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step;
        out_ready = 1'b0;
        check("valid_after_hs", out_valid, 0);
        check("done_pulse", done, 1);
        if (chain) begin
            start = 1'b1;
            step;
            start = 1'b0;
            chained = 1'b1;
        end else begin
            step;
        end
        check("done_cleared", done, 0);
    endtask

    function automatic vec_t mk(input int a, input int b, input int c,
                                input int d, input bit wr, input int wa,
                                input int wd, input logic [15:0] exp,
                                input bit tg, input int st, input bit ds);
        vec_t v;
        v.f       = {13'(d), 13'(c), 13'(b), 13'(a)};
        v.wr      = wr;
        v.wa      = 6'(wa);
        v.wd      = wd;
        v.exp     = exp;
        v.toggle  = tg;
        v.stall   = st;
        v.disturb = ds;
        return v;
    endfunction

    vec_t vecs[6];

    initial begin
        int          f[4];
        logic [15:0] res;

        vecs[0] = mk(3, 2, 1, 1, 0, 0, 0, 16'hF000, 0, 0, 0);
        vecs[1] = mk(10, 0, 0, 0, 0, 0, 0, 16'h7FFF, 1, 0, 0);
        vecs[2] = mk(0, 5, 5, 5, 0, 0, 0, 16'h8000, 0, 5, 0);
        vecs[3] = mk(3, 2, 1, 1, 0, 0, 0, 16'hF000, 1, 3, 1);
        vecs[4] = mk(3, 2, 1, 1, 1, 4, 3, 16'hF000, 0, 0, 0);
        vecs[5] = mk(0, 0, 2, 0, 1, 2, 3, 16'h6000, 0, 2, 0);

        rst = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
        start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        reset_model();
        step;
        step;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        step;

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].wr) write_w(vecs[v].wa, vecs[v].wd);
            for (int i = 0; i < 4; i++) f[i] = int'($signed(vecs[v].f[i]));
            run(f, vecs[v].toggle, vecs[v].stall, vecs[v].disturb, 0, res);
            check($sformatf("vec%0d_result", v), res, vecs[v].exp);
        end

        start = 1'b1;
        step;
        start = 1'b0;
        in_valid = 1'b1;
        in_data = 13'd3;
        step;
        in_data = 13'd2;
        step;
        in_valid = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        reset_model();
        check("abort_in_ready", in_ready, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_out_data", out_data, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        step;
        f = '{3, 2, 1, 1};
        run(f, 0, 0, 0, 1, res);
        check("after_abort_result", res, 16'hF000);
        f = '{10, 0, 0, 0};
        run(f, 0, 1, 0, 0, res);
        check("chained_result", res, 16'h7FFF);

        for (int n = 0; n < 40; n++) begin
            bit ch;
            if (!chained && $urandom_range(0, 1) == 1) begin
                write_w(6'($urandom_range(0, 5)),
                        int'($urandom_range(0, 8)) - 4);
            end
            for (int i = 0; i < 4; i++) begin
                if ($urandom_range(0, 3) == 0) f[i] = int'($urandom_range(0, 8191)) - 4096;
                else f[i] = int'($urandom_range(0, 16)) - 8;
            end
            ch = ($urandom_range(0, 2) == 0);
            run(f, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0, ch, res);
            check($sformatf("rand%0d_result", n), res, expect_q(f));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dense_neuron.md
# dense_neuron

Single fully-connected output neuron following the pooling stage of the CNN pipeline. It accepts a serial stream of N_IN signed pooled features, computes a bias-plus-weighted sum with run-time-loadable weights, and converts the sum to Q3.12 with saturation. The 16-bit result feeds the sigmoid stage over a valid/ready handshake, and a one-cycle done pulse marks completion.

## Interface
- N_IN, 4, features per inference (1..64)
- DW, 13, feature width, signed
- WW, 13, weight width, signed
- OW, 16, output width, signed Q3.12
- FRAC, 12, fractional bits of output
- ACCW, 32, accumulator width
- BIAS, 0, signed DW-bit bias preloaded into accumulator
- W_INIT, {-1,-1,-1,1}, packed N_IN*WW reset weights, w[0] in LSBs
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- w_we  in  1  weight write strobe
- w_addr  in  6  weight index
- w_data  in  WW  signed weight value
- start  in  1  begin one inference
- in_valid  in  1  feature beat valid
- in_data  in  DW  signed feature
- in_ready  out  1  feature beat accepted when in_valid&&in_ready
- out_valid  out  1  result valid
- out_data  out  OW  signed Q3.12 result to sigmoid
- out_ready  in  1  downstream accepts result
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, ACC, SCALE, HOLD.
- IDLE: acc <= sign-extended BIAS; idx <= 0. On start: go to ACC.
- ACC: in_ready = 1. On each accepted beat: acc <= acc + in_data*w[idx]; idx <= idx+1. When the beat with idx==N_IN-1 is accepted: go to SCALE.
- SCALE: out_data <= sat(acc << FRAC). Saturate to 0x7FFF if the result is above 32767, and to 0x8000 if below -32768. Go to HOLD.
- HOLD: out_valid = 1, out_data stable. On out_ready: go to IDLE, with done = 1 for exactly the next cycle.
- Weight writes take effect only in IDLE and only when w_addr < N_IN. Writes at any other time are ignored.
- start outside IDLE is ignored. in_valid outside ACC is ignored.
- The product is a full DW+WW signed width, sign-extended to ACCW. The accumulator cannot overflow for N_IN ≤ 64.

## Timing
- Reset values: in_ready=0, out_valid=0, out_data=0, busy=0, done=0, state=IDLE, acc=BIAS, idx=0, w[i]=W_INIT[i].
- rst in any state aborts the inference on the next edge. No done pulse and no out_valid are produced, and weights revert to W_INIT.
- start sampled at edge t gives in_ready=1 from cycle t+1.
- Zero-bubble streaming: one beat per cycle when in_valid is held high.
- Last beat accepted at edge k gives out_valid=1 from cycle k+2. Minimum latency from last beat to result is 2 cycles.
- Handshake at edge h gives out_valid=0 and done=1 during cycle h+1, then done=0. start is accepted from edge h+1.
- A start coincident with the done cycle launches the next inference.
- in_ready drops in the cycle after the last beat is accepted. A beat presented then is not consumed.

## Structure
- Shared package cnn_pkg holds:
  - the DW, WW, OW, FRAC and ACCW constants;
  - the state enum {IDLE, ACC, SCALE, HOLD};
  - the Q3.12 saturation limits 0x7FFF and 0x8000.
- Sub-module sat_shift: combinational ACCW-to-OW shift-left-by-FRAC with saturation, reused by later dense stages.
- The weight store is a register array, not inferred RAM, so that it can be reset.

## Test plan
- Default weights, BIAS=0, features 3,2,1,1 back-to-back → out_data=0xF000 (-4096, i.e. -1.0) at 2 cycles after the last beat, then done pulses once.
- Features 10,0,0,0 → positive saturation, out_data=0x7FFF. Features 0,5,5,5 (sum -15) → out_data=0x8000.
- In IDLE, write w_addr=2, w_data=3, then features 0,0,2,0 → out_data=0x6000. A write with w_addr=4 leaves the weights unchanged.
- in_valid toggled every other cycle → each beat is consumed exactly once. With out_ready held low for 5 cycles, out_valid and out_data are held; done pulses only after the handshake.
- rst asserted after 2 accepted beats → all outputs return to their reset values next cycle. A fresh run with 3,2,1,1 then yields 0xF000, with no stale accumulation.
- start pulsed during ACC, and in_valid driven in HOLD → both ignored; the result matches the undisturbed run.
